// File: rtl/ll_sram_arbiter.sv
// Next-pointer SRAM arbiter: shares one 1RW SRAM (1-cycle read latency) between
// 4 link-list writers, 4 next-address readers and the drop path. Each requester
// has a one-entry buffer; one SRAM access is issued per cycle.
module ll_sram_arbiter #(
    parameter int unsigned ADDR_LENTH = 12,
    parameter int unsigned DROP_AGE   = 8
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic [3:0]              iWriteLaddrVld,
    output logic [3:0]              oWriteLaddrRdy,
    input  logic [4*ADDR_LENTH-1:0] iWriteLaddr,
    input  logic [4*ADDR_LENTH-1:0] iWriteLdata,
    input  logic [3:0]              iLNxtAddrReq,
    output logic [3:0]              oLNxtAddrRdy,
    input  logic [4*ADDR_LENTH-1:0] iLaddr,
    output logic [4*ADDR_LENTH-1:0] oLdata,
    output logic [3:0]              oLdataVld,
    input  logic                    iDropAddrVld,
    output logic                    oDropAddrRdy,
    input  logic [ADDR_LENTH-1:0]   iDropAddr,
    output logic [ADDR_LENTH-1:0]   oDropData,
    output logic                    oDropDataVld,
    output logic                    oSramEn,
    output logic                    oSramWe,
    output logic [ADDR_LENTH-1:0]   oSramAddr,
    output logic [ADDR_LENTH-1:0]   oSramWdata,
    input  logic [ADDR_LENTH-1:0]   iSramRdata
);

    localparam int unsigned AW   = ADDR_LENTH;
    localparam int unsigned AgeW = $clog2(DROP_AGE + 1);

    // Request buffers
    logic [3:0]    wr_pend_q, wr_pend_d;
    logic [3:0]    rd_pend_q, rd_pend_d;
    logic          drop_pend_q, drop_pend_d;
    logic [AW-1:0] wr_addr_q [4];
    logic [AW-1:0] wr_data_q [4];
    logic [AW-1:0] rd_addr_q [4];
    logic [AW-1:0] drop_addr_q;

    // Arbitration state
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [AgeW-1:0] age_q, age_d;

    // SRAM drive and read-return pipeline
    logic          sram_en_q, sram_we_q;
    logic [AW-1:0] sram_addr_q, sram_wdata_q;
    logic [2:0]    tag_q;
    logic          ret_vld_q;
    logic [2:0]    ret_tag_q;
    logic [4*AW-1:0] ldata_q;
    logic [3:0]      ldata_vld_q;
    logic [AW-1:0]   drop_data_q;
    logic            drop_vld_q;

    // Grant decode
    logic [3:0]    wr_acc, rd_acc;
    logic          drop_acc;
    logic          wr_any, rd_any, drop_aged;
    logic [1:0]    wr_idx, rd_idx, wr_cand, rd_cand;
    logic          gnt_wr, gnt_rd, gnt_drop;
    logic [1:0]    gnt_idx;
    logic [AW-1:0] gnt_addr;

    assign wr_acc   = iWriteLaddrVld & ~wr_pend_q;
    assign rd_acc   = iLNxtAddrReq & ~rd_pend_q;
    assign drop_acc = iDropAddrVld & ~drop_pend_q;

    assign oWriteLaddrRdy = ~wr_pend_q;
    assign oLNxtAddrRdy   = ~rd_pend_q;
    assign oDropAddrRdy   = ~drop_pend_q;
    assign oSramEn        = sram_en_q;
    assign oSramWe        = sram_we_q;
    assign oSramAddr      = sram_addr_q;
    assign oSramWdata     = sram_wdata_q;
    assign oLdata         = ldata_q;
    assign oLdataVld      = ldata_vld_q;
    assign oDropData      = drop_data_q;
    assign oDropDataVld   = drop_vld_q;

    // Round-robin search: descending loop so the candidate closest to the pointer wins
    always_comb begin
        wr_any  = 1'b0;
        rd_any  = 1'b0;
        wr_idx  = wr_ptr_q;
        rd_idx  = rd_ptr_q;
        wr_cand = wr_ptr_q;
        rd_cand = rd_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            wr_cand = wr_ptr_q + 2'(k);
            rd_cand = rd_ptr_q + 2'(k);
            if (wr_pend_q[wr_cand]) begin
                wr_any = 1'b1;
                wr_idx = wr_cand;
            end
            if (rd_pend_q[rd_cand]) begin
                rd_any = 1'b1;
                rd_idx = rd_cand;
            end
        end
    end

    // Fixed class priority: aged drop, writes, reads, drop
    always_comb begin
        gnt_wr    = 1'b0;
        gnt_rd    = 1'b0;
        gnt_drop  = 1'b0;
        gnt_idx   = 2'd0;
        drop_aged = drop_pend_q && (age_q >= AgeW'(DROP_AGE));
        if (drop_aged) begin
            gnt_drop = 1'b1;
        end else if (wr_any) begin
            gnt_wr  = 1'b1;
            gnt_idx = wr_idx;
        end else if (rd_any) begin
            gnt_rd  = 1'b1;
            gnt_idx = rd_idx;
        end else if (drop_pend_q) begin
            gnt_drop = 1'b1;
        end
    end

    // Next state for pending flags, pointers, age counter and grant address
    always_comb begin
        wr_pend_d   = wr_pend_q | wr_acc;
        rd_pend_d   = rd_pend_q | rd_acc;
        drop_pend_d = drop_pend_q | drop_acc;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        age_d       = age_q;
        gnt_addr    = drop_addr_q;
        if (gnt_wr) begin
            wr_pend_d = wr_pend_d & ~(4'b0001 << gnt_idx);
            wr_ptr_d  = gnt_idx + 2'd1;
            gnt_addr  = wr_addr_q[gnt_idx];
        end
        if (gnt_rd) begin
            rd_pend_d = rd_pend_d & ~(4'b0001 << gnt_idx);
            rd_ptr_d  = gnt_idx + 2'd1;
            gnt_addr  = rd_addr_q[gnt_idx];
        end
        if (gnt_drop) begin
            drop_pend_d = 1'b0;
            age_d       = '0;
        end else if (drop_pend_q && (age_q < AgeW'(DROP_AGE))) begin
            age_d = age_q + AgeW'(1);
        end
    end

    // Control state registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wr_pend_q   <= '0;
            rd_pend_q   <= '0;
            drop_pend_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            age_q       <= '0;
        end else begin
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            drop_pend_q <= drop_pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            age_q       <= age_d;
        end
    end

    // Request payload capture on accept
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < 4; i++) begin
                wr_addr_q[i] <= '0;
                wr_data_q[i] <= '0;
                rd_addr_q[i] <= '0;
            end
            drop_addr_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_acc[i]) begin
                    wr_addr_q[i] <= iWriteLaddr[i*AW +: AW];
                    wr_data_q[i] <= iWriteLdata[i*AW +: AW];
                end
                if (rd_acc[i]) begin
                    rd_addr_q[i] <= iLaddr[i*AW +: AW];
                end
            end
            if (drop_acc) begin
                drop_addr_q <= iDropAddr;
            end
        end
    end

    // SRAM issue one cycle after grant; address/wdata hold while idle
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            tag_q        <= '0;
        end else begin
            sram_en_q <= gnt_wr | gnt_rd | gnt_drop;
            if (gnt_wr | gnt_rd | gnt_drop) begin
                sram_we_q   <= gnt_wr;
                sram_addr_q <= gnt_addr;
                tag_q       <= {gnt_drop, gnt_idx};
            end
            if (gnt_wr) begin
                sram_wdata_q <= wr_data_q[gnt_idx];
            end
        end
    end

    // Read return: tag follows the SRAM latency, data registered to its owner
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ret_vld_q   <= 1'b0;
            ret_tag_q   <= '0;
            ldata_q     <= '0;
            ldata_vld_q <= '0;
            drop_data_q <= '0;
            drop_vld_q  <= 1'b0;
        end else begin
            ret_vld_q   <= sram_en_q & ~sram_we_q;
            ret_tag_q   <= tag_q;
            ldata_vld_q <= '0;
            drop_vld_q  <= 1'b0;
            if (ret_vld_q) begin
                if (ret_tag_q[2]) begin
                    drop_vld_q  <= 1'b1;
                    drop_data_q <= iSramRdata;
                end else begin
                    ldata_vld_q[ret_tag_q[1:0]]       <= 1'b1;
                    ldata_q[ret_tag_q[1:0]*AW +: AW] <= iSramRdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ll_sram_arbiter.sv
// Directed bench for ll_sram_arbiter with a behavioural 1RW SRAM model.
module tb_ll_sram_arbiter;

    localparam int unsigned AW = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      wr_vld, wr_rdy, rd_req, rd_rdy, ldata_vld;
    logic [4*AW-1:0] wr_addr, wr_data, rd_addr, ldata;
    logic            drop_vld, drop_rdy, drop_dvld;
    logic [AW-1:0]   drop_addr, drop_data;
    logic            sram_en, sram_we;
    logic [AW-1:0]   sram_addr, sram_wdata, sram_rdata;
    logic [AW-1:0]   mem [4096];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ll_sram_arbiter #(.ADDR_LENTH(AW), .DROP_AGE(8)) dut (
        .iClk           (clk),
        .iRst_n         (rst_n),
        .iWriteLaddrVld (wr_vld),
        .oWriteLaddrRdy (wr_rdy),
        .iWriteLaddr    (wr_addr),
        .iWriteLdata    (wr_data),
        .iLNxtAddrReq   (rd_req),
        .oLNxtAddrRdy   (rd_rdy),
        .iLaddr         (rd_addr),
        .oLdata         (ldata),
        .oLdataVld      (ldata_vld),
        .iDropAddrVld   (drop_vld),
        .oDropAddrRdy   (drop_rdy),
        .iDropAddr      (drop_addr),
        .oDropData      (drop_data),
        .oDropDataVld   (drop_dvld),
        .oSramEn        (sram_en),
        .oSramWe        (sram_we),
        .oSramAddr      (sram_addr),
        .oSramWdata     (sram_wdata),
        .iSramRdata     (sram_rdata)
    );

    // SRAM model: mem[i] preset to i*3, read data valid the cycle after enable
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 12'(i * 3);
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            if (sram_en) begin
                if (sram_we) mem[sram_addr] <= sram_wdata;
                else         sram_rdata     <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_vld   = '0;
        rd_req   = '0;
        drop_vld = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int cnt;
        logic [AW-1:0] got;
        logic [AW-1:0] wlog [3];
        logic [7:0] gmask;

        rst_n = 1'b0; wr_vld = '0; rd_req = '0; drop_vld = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0; drop_addr = '0;
        repeat (2) tick();
        // Reset state
        check("rst_rdy", {drop_rdy, rd_rdy, wr_rdy}, 9'h1FF);
        check("rst_en", sram_en, 0);
        check("rst_vld", {drop_dvld, ldata_vld}, 0);
        check("rst_ldata", ldata, 0);
        check("rst_addr", sram_addr, 0);
        rst_n = 1'b1;
        tick();

        // Write port0 addr 5 data 9, then read it back
        wr_addr[0 +: AW] = 12'd5; wr_data[0 +: AW] = 12'd9; wr_vld = 4'b0001;
        tick(); wr_vld = '0;
        check("wr_rdy_low", wr_rdy, 4'b1110);
        tick();
        check("wr_issue", {sram_en, sram_we, sram_addr, sram_wdata}, {2'b11, 12'd5, 12'd9});
        check("wr_rdy_back", wr_rdy, 4'hF);
        rd_addr[0 +: AW] = 12'd5; rd_req = 4'b0001;
        tick(); rd_req = '0;
        check("rd_rdy_low", rd_rdy, 4'b1110);
        cnt = 0; got = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) check("rd_issue", {sram_en, sram_we, sram_addr}, {2'b10, 12'd5});
            if (ldata_vld[0]) begin cnt++; got = ldata[0 +: AW]; end
        end
        check("wr_rd_vld_cnt", cnt, 1);
        check("wr_rd_data", got, 9);

        // All 8 requesters at once from pointers 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_addr[i*AW +: AW] = 12'(16'h10 + i);
            wr_data[i*AW +: AW] = 12'(16'h20 + i);
            rd_addr[i*AW +: AW] = 12'(16'h30 + i);
        end
        wr_vld = 4'hF; rd_req = 4'hF;
        tick(); wr_vld = '0; rd_req = '0;
        for (int j = 0; j < 8; j++) begin
            tick();
            gmask = 8'((9'd1 << (j + 1)) - 9'd1);
            check($sformatf("all8_en%0d", j), {sram_en, sram_we}, {1'b1, j < 4});
            check($sformatf("all8_addr%0d", j), sram_addr,
                  (j < 4) ? 32'(16'h10 + j) : 32'(16'h30 + j - 4));
            check($sformatf("all8_rdy%0d", j), {rd_rdy, wr_rdy}, gmask);
        end
        tick();
        check("all8_idle", sram_en, 0);

        // Drop aging against continuous writes
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_addr[i*AW +: AW] = 12'(16'h100 + i);
            wr_data[i*AW +: AW] = 12'(16'h300 + i);
        end
        wr_vld = 4'hF; drop_addr = 12'd7; drop_vld = 1'b1;
        tick(); drop_vld = 1'b0;
        check("drop_rdy_low", drop_rdy, 0);
        for (int k = 2; k <= 9; k++) begin
            tick();
            check($sformatf("age_wr%0d", k), {sram_en, sram_we}, 2'b11);
        end
        check("age_sat", dut.age_q, 8);
        tick();
        check("drop_issue", {sram_en, sram_we, sram_addr}, {2'b10, 12'd7});
        check("age_clr", dut.age_q, 0);
        check("drop_rdy_back", drop_rdy, 1);
        tick(); tick();
        check("drop_data", {drop_dvld, drop_data}, {1'b1, 12'd21});
        tick();
        check("drop_pulse", drop_dvld, 0);
        wr_vld = '0;

        // Round-robin fairness on reads
        do_reset();
        rd_addr[2*AW +: AW] = 12'h40; rd_req = 4'b0100;
        tick(); rd_req = '0;
        tick();
        check("rr_first", {sram_en, sram_we, sram_addr}, {2'b10, 12'h40});
        rd_addr[0 +: AW] = 12'h50; rd_addr[2*AW +: AW] = 12'h52; rd_req = 4'b0101;
        tick(); rd_req = '0;
        tick();
        check("rr_p0", sram_addr, 12'h50);
        tick();
        check("rr_p2", sram_addr, 12'h52);
        rd_addr[1*AW +: AW] = 12'h61; rd_addr[3*AW +: AW] = 12'h63; rd_req = 4'b1010;
        tick(); rd_req = '0;
        tick();
        check("rr_p3", sram_addr, 12'h63);
        tick();
        check("rr_p1", sram_addr, 12'h61);

        // Reset while a read is in flight
        do_reset();
        rd_addr[1*AW +: AW] = 12'd5; rd_req = 4'b0010;
        tick(); rd_req = '0;
        tick();
        check("mid_issue", {sram_en, sram_we}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("mid_rdy", {drop_rdy, rd_rdy, wr_rdy}, 9'h1FF);
        check("mid_en", sram_en, 0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) rst_n = 1'b1;
            tick();
            if ((ldata_vld != 0) || drop_dvld) cnt++;
        end
        check("mid_no_vld", cnt, 0);

        // Back-pressure: port1 valid held for 5 cycles
        do_reset();
        wr_addr[1*AW +: AW] = 12'h77;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 5) begin
                wr_vld = 4'b0010;
                wr_data[1*AW +: AW] = 12'(16'h200 + k);
            end else begin
                wr_vld = '0;
            end
            tick();
            if (k < 5) check($sformatf("bp_rdy%0d", k), wr_rdy[1], (k % 2 == 0) ? 0 : 1);
            if (sram_en && sram_we) begin
                if (cnt < 3) wlog[cnt] = sram_wdata;
                check($sformatf("bp_addr%0d", cnt), sram_addr, 12'h77);
                cnt++;
            end
        end
        check("bp_wr_cnt", cnt, 3);
        check("bp_data0", wlog[0], 12'h200);
        check("bp_data1", wlog[1], 12'h202);
        check("bp_data2", wlog[2], 12'h204);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
